uart_rx_reg: RTL and testbench

//  Memory-mapped UART receiver: 8N1 deserialiser with 16x oversampling and a

---
 rtl/uart_rx_reg.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_reg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_reg.sv
// uart_rx_reg: memory-mapped 8N1 UART receiver, 16x oversampling,
// programmable baud divisor and a small load/store register file.
module uart_rx_reg #(
  parameter int                DVSR_W       = 11,
  parameter logic [DVSR_W-1:0] DEFAULT_DVSR = DVSR_W'(650),
  parameter int                DBITS        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [4:0]  address,
  input  logic [31:0] data_in,
  input  logic        rx,
  output logic [31:0] cout,
  output logic        rx_valid,
  output logic        rx_busy
);
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [3:0]        s_cnt;
  logic [NW-1:0]     n;
  logic [DBITS-1:0]  shreg;
  logic [DBITS-1:0]  data;
  logic              valid;
  logic              overrun;
  logic              ferr;
  logic              rx_en;
  logic [DVSR_W-1:0] dvsr;
  logic [DVSR_W-1:0] b_cnt;
  logic [1:0]        rx_sync;
  logic              rx_s;
  logic              tick;
  logic [2:0]        word;
  logic              wr0;
  logic              wr1;
  logic              wr2;
  logic              rd0;
  logic              clr_valid;
  logic              en_next;
  logic              commit;
  logic              unused_bits;

  assign word        = address[4:2];
  assign wr0         = write_enable && (word == 3'd0);
  assign wr1         = write_enable && (word == 3'd1);
  assign wr2         = write_enable && (word == 3'd2);
  assign rd0         = read_enable && (word == 3'd0);
  assign clr_valid   = wr0 || rd0;
  assign rx_s        = rx_sync[1];
  assign tick        = (b_cnt == dvsr);
  assign unused_bits = ^{address[1:0], data_in[31:DVSR_W]};

  // A CTRL store that drops rx_en aborts the frame on the same edge
  assign en_next = wr2 ? data_in[0] : rx_en;
  assign commit  = en_next && (state == STOP) && tick && (s_cnt == 4'd15);

  assign rx_valid = valid;
  assign rx_busy  = (state != IDLE);

  always_comb begin
    cout = '0;
    case (word)
      3'd0:    cout = {valid, overrun, ferr, {(29-DBITS){1'b0}}, data};
      3'd1:    cout = {{(32-DVSR_W){1'b0}}, dvsr};
      3'd2:    cout = {31'b0, rx_en};
      default: cout = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync <= 2'b11;
      b_cnt   <= '0;
      dvsr    <= DEFAULT_DVSR;
      rx_en   <= 1'b0;
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      if (wr1) begin
        dvsr  <= data_in[DVSR_W-1:0];
        b_cnt <= '0;
      end else if (tick) begin
        b_cnt <= '0;
      end else begin
        b_cnt <= b_cnt + DVSR_W'(1);
      end
      if (wr2) rx_en <= data_in[0];
      if (clr_valid) valid <= 1'b0;
      if (wr0) begin
        overrun <= 1'b0;
        ferr    <= 1'b0;
      end
      // A landing byte beats a same-cycle clear of word0
      if (commit) begin
        if (!rx_s) begin
          ferr <= 1'b1;
        end else if (!valid || clr_valid) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s_cnt <= '0;
      n     <= '0;
      shreg <= '0;
    end else if (!en_next) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == 4'd7) begin
              s_cnt <= '0;
              n     <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == 4'd15) begin
              shreg <= {rx_s, shreg[DBITS-1:1]};
              s_cnt <= '0;
              if (n == NW'(DBITS-1)) state <= STOP;
              else n <= n + NW'(1);
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt == 4'd15) begin
              state <= IDLE;
              s_cnt <= '0;
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_reg.sv
// tb_uart_rx_reg: table vectors, corner sequences and random frames
// checked against a frame-level model of the receive register.
module tb_uart_rx_reg;
  logic        clk;
  logic        rst;
  logic        write_enable;
  logic        read_enable;
  logic [4:0]  address;
  logic [31:0] data_in;
  logic        rx;
  logic [31:0] cout;
  logic        rx_valid;
  logic        rx_busy;

  int npass = 0;
  int ntot  = 0;

  logic       m_valid;
  logic       m_ovr;
  logic       m_ferr;
  logic [7:0] m_data;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] e;
  } reg_vec_t;

  typedef struct {
    logic [7:0]  b;
    logic        stop;
    int          clr_at;
    logic        clr_wr;
    logic [31:0] exp_w;
    int          post;
    logic [31:0] exp_post;
  } frame_vec_t;

  reg_vec_t   rv[6];
  frame_vec_t fv[11];

  uart_rx_reg dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address      (address),
    .data_in      (data_in),
    .rx           (rx),
    .cout         (cout),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %08h expected %08h", nm, got, exp);
  endtask

  task automatic peek(input logic [4:0] a, input string nm,
                      input logic [31:0] exp);
    address = a;
    #1 chk(nm, cout, exp);
    @(negedge clk);
  endtask

  task automatic store(input logic [4:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic read0(input string nm, input logic [31:0] pre,
                       input logic [31:0] post);
    address     = 5'd0;
    read_enable = 1'b1;
    #1 chk({nm, "_pre"}, cout, pre);
    @(negedge clk);
    read_enable = 1'b0;
    #1 chk({nm, "_post"}, cout, post);
    @(negedge clk);
  endtask

  // Frame is start + 8 data (LSB first) + stop, bl clocks per bit.
  // clr_at >= 0 pulses a read or store of word0 on that clock.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int clr_at, input logic clr_wr,
                            input int bl);
    logic [9:0] bits;
    bits    = {stop, b, 1'b0};
    data_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 10 * bl; i++) begin
      rx = bits[i / bl];
      if (i == clr_at) begin
        address      = 5'd0;
        write_enable = clr_wr;
        read_enable  = !clr_wr;
      end else begin
        write_enable = 1'b0;
        read_enable  = 1'b0;
      end
      @(negedge clk);
    end
    rx           = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [31:0] m_word();
    return {m_valid, m_ovr, m_ferr, 21'b0, m_data};
  endfunction

  task automatic m_commit(input logic [7:0] b, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin
      m_data  = b;
      m_valid = 1'b1;
    end
  endtask

  initial begin
    rv[0] = '{5'd0,  32'd0};
    rv[1] = '{5'd4,  32'd650};
    rv[2] = '{5'd5,  32'd650};
    rv[3] = '{5'd8,  32'd0};
    rv[4] = '{5'd12, 32'd0};
    rv[5] = '{5'd28, 32'd0};

    fv[0]  = '{8'hA5, 1'b1, -1,  1'b0, 32'h8000_00A5, 1, 32'h0000_00A5};
    fv[1]  = '{8'h3C, 1'b1, -1,  1'b0, 32'h8000_003C, 0, 32'h0};
    fv[2]  = '{8'h11, 1'b1, -1,  1'b0, 32'hC000_003C, 0, 32'h0};
    fv[3]  = '{8'h5A, 1'b0, -1,  1'b0, 32'hE000_003C, 2, 32'h0000_003C};
    fv[4]  = '{8'h77, 1'b1, 154, 1'b0, 32'h8000_0077, 0, 32'h0};
    fv[5]  = '{8'h99, 1'b1, 154, 1'b0, 32'h8000_0099, 1, 32'h0000_0099};
    fv[6]  = '{8'h42, 1'b1, -1,  1'b0, 32'h8000_0042, 0, 32'h0};
    fv[7]  = '{8'h13, 1'b0, 154, 1'b1, 32'h2000_0042, 2, 32'h0000_0042};
    fv[8]  = '{8'h5A, 1'b0, -1,  1'b0, 32'h2000_0042, 0, 32'h0};
    fv[9]  = '{8'hE7, 1'b1, 154, 1'b1, 32'h8000_00E7, 0, 32'h0};
    fv[10] = '{8'hC3, 1'b1, 154, 1'b1, 32'h8000_00C3, 2, 32'h0000_00C3};

    rst          = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    address      = 5'd0;
    data_in      = 32'd0;
    rx           = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("rst_busy", {31'b0, rx_busy}, 32'd0);
    chk("rst_valid", {31'b0, rx_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    foreach (rv[i]) peek(rv[i].a, $sformatf("rst_reg%0d", i), rv[i].e);

    store(5'd4, 32'd0);
    store(5'd8, 32'd1);
    store(5'd20, 32'hFFFF_FFFF);
    peek(5'd4, "dvsr0", 32'd0);
    peek(5'd8, "ctrl_en", 32'd1);
    peek(5'd20, "w5_ign", 32'd0);

    foreach (fv[i]) begin
      send_frame(fv[i].b, fv[i].stop, fv[i].clr_at, fv[i].clr_wr, 16);
      address = 5'd0;
      #1 chk($sformatf("fv%0d_w0", i), cout, fv[i].exp_w);
      chk($sformatf("fv%0d_rxv", i), {31'b0, rx_valid},
          {31'b0, fv[i].exp_w[31]});
      @(negedge clk);
      if (fv[i].post == 1) begin
        read0($sformatf("fv%0d_rd", i), fv[i].exp_w, fv[i].exp_post);
      end else if (fv[i].post == 2) begin
        store(5'd0, 32'hFFFF_FFFF);
        peek(5'd0, $sformatf("fv%0d_st", i), fv[i].exp_post);
      end
    end

    // Short low pulse is rejected at the mid-start check
    for (int i = 0; i < 24; i++) begin
      rx = (i >= 4);
      if (i == 6) begin
        #1 chk("glitch_busy", {31'b0, rx_busy}, 32'd1);
      end
      @(negedge clk);
    end
    #1 chk("glitch_idle", {31'b0, rx_busy}, 32'd0);
    peek(5'd0, "glitch_w0", 32'h0000_00C3);

    // Abort in bit 3 by clearing rx_en
    for (int i = 0; i < 72; i++) begin
      rx = (i < 16) ? 1'b0 : ((8'h5A >> ((i - 16) / 16)) & 8'h1) != 0;
      @(negedge clk);
    end
    #1 chk("abort_pre", {31'b0, rx_busy}, 32'd1);
    rx = 1'b1;
    store(5'd8, 32'd0);
    #1 chk("abort_busy", {31'b0, rx_busy}, 32'd0);
    repeat (100) @(negedge clk);
    peek(5'd0, "abort_w0", 32'h0000_00C3);
    store(5'd8, 32'd1);
    send_frame(8'h81, 1'b1, -1, 1'b0, 16);
    peek(5'd0, "after_abort", 32'h8000_0081);

    store(5'd0, 32'd0);
    store(5'd4, 32'd1);
    peek(5'd4, "dvsr1", 32'd1);
    send_frame(8'h6B, 1'b1, -1, 1'b0, 32);
    peek(5'd0, "dvsr1_w0", 32'h8000_006B);
    store(5'd0, 32'd0);
    store(5'd4, 32'd0);

    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_data  = 8'h6B;
    for (int k = 0; k < 14; k++) begin
      logic [7:0] b;
      logic       stop;
      int         post;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop, -1, 1'b0, 16);
      m_commit(b, stop);
      peek(5'd0, $sformatf("rnd%0d", k), m_word());
      post = $urandom_range(0, 5);
      if (post <= 2) begin
        logic [31:0] pre;
        pre     = m_word();
        m_valid = 1'b0;
        read0($sformatf("rnd%0d_rd", k), pre, m_word());
      end else if (post == 3) begin
        store(5'd0, 32'd0);
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        peek(5'd0, $sformatf("rnd%0d_st", k), m_word());
      end
    end

    // Reset in the middle of a frame
    for (int i = 0; i < 100; i++) begin
      rx = (i < 16) ? 1'b0 : ((8'hF0 >> ((i - 16) / 16)) & 8'h1) != 0;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    #1 chk("mid_rst_busy", {31'b0, rx_busy}, 32'd0);
    peek(5'd0, "mid_rst_w0", 32'd0);
    peek(5'd4, "mid_rst_dvsr", 32'd650);
    peek(5'd8, "mid_rst_ctrl", 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
